// File: rtl/data_memory_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_if
//  Description : Request/response bundle between a requester and data_memory.
//  Revision    : 1.0  initial release
// ============================================================================
interface data_memory_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
);
    logic                 req;
    logic                 we;
    logic [WIDTH/8-1:0]   wstrb;
    logic [ADDR_W-1:0]    addr;
    logic [WIDTH-1:0]     din;
    logic                 clr;
    logic                 ready;
    logic                 rvalid;
    logic [WIDTH-1:0]     dout;
    logic                 busy;
    logic                 err;

    modport master (
        output req, we, wstrb, addr, din, clr,
        input  ready, rvalid, dout, busy, err
    );

    modport slave (
        input  req, we, wstrb, addr, din, clr,
        output ready, rvalid, dout, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory
//  Description : Byte-strobed single-port word memory with a zeroing sweep
//                after reset or on request. Optional out-of-range rejection
//                is enabled by defining DATA_MEMORY_RANGE_CHECK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module data_memory #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  wire logic     clk,
    input  wire logic     rst,
    data_memory_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LANES = WIDTH / 8;

    localparam logic [0:0]       c_ST_CLEAR = 1'b0;
    localparam logic [0:0]       c_ST_IDLE  = 1'b1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(DEPTH - 1);

    logic [0:0]       state_q,   state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic             rvalid_q,  rvalid_d;
    logic             err_q,     err_d;
    logic [WIDTH-1:0] dout_q,    dout_d;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             w_accept;
    logic             w_in_range;
    logic [IDX_W-1:0] w_idx;
    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    logic [WIDTH-1:0] w_wr_data;
    logic [LANES-1:0] w_wr_strb;

    // Modulo keeps any address inside the array, even for non power-of-two depths.
    assign w_idx = IDX_W'(bus.addr % ADDR_W'(DEPTH));

`ifdef DATA_MEMORY_RANGE_CHECK_EN
    assign w_in_range = (bus.addr < ADDR_W'(DEPTH));
`else
    assign w_in_range = 1'b1;
`endif

    // A clear request wins over a same-cycle access.
    assign w_accept = bus.req & (state_q == c_ST_IDLE) & ~bus.clr;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        rvalid_d  = 1'b0;
        err_d     = 1'b0;
        dout_d    = dout_q;
        w_wr_en   = 1'b0;
        w_wr_idx  = w_idx;
        w_wr_data = bus.din;
        w_wr_strb = bus.wstrb;

        case (state_q)
            c_ST_CLEAR: begin
                w_wr_en   = 1'b1;
                w_wr_idx  = clr_idx_q;
                w_wr_data = '0;
                w_wr_strb = '1;
                if (clr_idx_q == c_LAST_IDX) begin
                    state_d   = c_ST_IDLE;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            default: begin
                if (bus.clr) begin
                    state_d = c_ST_CLEAR;
                end else if (w_accept) begin
                    if (!w_in_range) begin
                        err_d = 1'b1;
                    end else if (bus.we) begin
                        w_wr_en = 1'b1;
                    end else begin
                        rvalid_d = 1'b1;
                        dout_d   = mem_q[w_idx];
                    end
                end
            end
        endcase

        if (rst) begin
            w_wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= c_ST_CLEAR;
            clr_idx_q <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            dout_q    <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_wr_strb[i]) begin
                    mem_q[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
                end
            end
        end
    end

    assign bus.ready  = (state_q == c_ST_IDLE);
    assign bus.busy   = (state_q == c_ST_CLEAR);
    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;
    assign bus.dout   = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory
//  Description : Self-checking bench for data_memory against an array model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_memory;
    logic clk = 1'b0;
    logic rst = 1'b1;

    data_memory_if #(.WIDTH(32), .ADDR_W(32)) bus ();

    data_memory #(.WIDTH(32), .DEPTH(256), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] ref_mem [256];
    logic [31:0] ref_dout;
    int          checks = 0;
    int          errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.req = 1'b0; bus.we = 1'b0; bus.clr = 1'b0;
        bus.wstrb = '0; bus.addr = '0; bus.din = '0;
    endtask

    function automatic void model_zero();
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
`ifdef DATA_MEMORY_RANGE_CHECK_EN
        if (a >= 256) return;
`endif
        for (int i = 0; i < 4; i++)
            if (s[i]) ref_mem[a % 256][8*i +: 8] = d[8*i +: 8];
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = a; bus.din = d; bus.wstrb = s;
        tick();
        bus.req = 1'b0; bus.we = 1'b0;
        model_write(a, d, s);
    endtask

    task automatic wait_sweep(output int cycles);
        cycles = 0;
        while (bus.busy && cycles < 600) begin
            cycles++;
            tick();
        end
    endtask

    task automatic test_reset();
        int n;
        idle_bus();
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.busy, bus.ready, bus.rvalid, bus.err, bus.dout} !== {4'b1000, 32'h0}) begin
            errors++;
            $display("FAIL reset_state: got busy/ready/rvalid/err/dout %b%b%b%b %h exp 1000 00000000",
                     bus.busy, bus.ready, bus.rvalid, bus.err, bus.dout);
        end
        rst = 1'b0;
        wait_sweep(n);
        checks++;
        if (n !== 256) begin errors++; $display("FAIL reset_sweep_len: got %0d exp 256", n); end
        checks++;
        if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", bus.ready); end
        model_zero();
        ref_dout = '0;
        for (int a = 0; a < 256; a++) begin
            bus.req = 1'b1; bus.we = 1'b0; bus.addr = a;
            tick();
            checks++;
            if ({bus.rvalid, bus.dout} !== {1'b1, 32'h0}) begin
                errors++;
                $display("FAIL reset_zero[%0d]: got rvalid %b dout %h exp 1 00000000", a, bus.rvalid, bus.dout);
            end
        end
        bus.req = 1'b0;
    endtask

    task automatic test_strobe();
        logic [31:0] addrs [40];
        wr(5, 32'hDEADBEEF, 4'hF);
        wr(5, 32'h00000011, 4'h1);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 5;
        tick();
        bus.req = 1'b0;
        checks++;
        if ({bus.rvalid, bus.dout} !== {1'b1, 32'hDEADBE11}) begin
            errors++;
            $display("FAIL strobe_merge: got rvalid %b dout %h exp 1 deadbe11", bus.rvalid, bus.dout);
        end
        ref_dout = 32'hDEADBE11;
        tick();
        checks++;
        if ({bus.rvalid, bus.dout} !== {1'b0, ref_dout}) begin
            errors++;
            $display("FAIL dout_hold: got rvalid %b dout %h exp 0 %h", bus.rvalid, bus.dout, ref_dout);
        end
        for (int k = 0; k < 40; k++) begin
            addrs[k] = $urandom_range(0, 255);
            wr(addrs[k], $urandom, 4'($urandom));
        end
        for (int k = 0; k < 40; k++) begin
            bus.req = 1'b1; bus.we = 1'b0; bus.addr = addrs[k];
            tick();
            checks++;
            if ({bus.rvalid, bus.dout} !== {1'b1, ref_mem[addrs[k]]}) begin
                errors++;
                $display("FAIL strobe_rand[%0d]: got %b %h exp 1 %h", addrs[k], bus.rvalid, bus.dout, ref_mem[addrs[k]]);
            end
            ref_dout = ref_mem[addrs[k]];
        end
        bus.req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        wr(9, 32'h12345678, 4'hF);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 9;
        tick();
        checks++;
        if ({bus.rvalid, bus.dout} !== {1'b1, 32'h12345678}) begin
            errors++;
            $display("FAIL raw_next_cycle: got %b %h exp 1 12345678", bus.rvalid, bus.dout);
        end
        for (int k = 0; k < 4; k++) begin
            a = $urandom_range(0, 255);
            bus.addr = a;
            tick();
            checks++;
            if ({bus.rvalid, bus.dout} !== {1'b1, ref_mem[a]}) begin
                errors++;
                $display("FAIL b2b_read[%0d]: got %b %h exp 1 %h", k, bus.rvalid, bus.dout, ref_mem[a]);
            end
            ref_dout = ref_mem[a];
        end
        bus.req = 1'b0;
        tick();
        checks++;
        if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL b2b_end: got rvalid %b exp 0", bus.rvalid); end
    endtask

    task automatic test_random_traffic();
        logic        e_rv, e_err;
        logic [31:0] e_dout;
        for (int k = 0; k < 300; k++) begin
            bus.req   = ($urandom_range(0, 3) != 0);
            bus.we    = $urandom_range(0, 1);
            bus.addr  = $urandom_range(0, 299);
            bus.din   = $urandom;
            bus.wstrb = 4'($urandom);
            e_rv = 1'b0; e_err = 1'b0; e_dout = ref_dout;
            if (bus.req) begin
`ifdef DATA_MEMORY_RANGE_CHECK_EN
                if (bus.addr >= 256) e_err = 1'b1;
                else
`endif
                if (!bus.we) begin e_rv = 1'b1; e_dout = ref_mem[bus.addr % 256]; end
            end
            tick();
            checks++;
            if ({bus.rvalid, bus.err, bus.dout} !== {e_rv, e_err, e_dout}) begin
                errors++;
                $display("FAIL random[%0d]: got rvalid %b err %b dout %h exp %b %b %h",
                         k, bus.rvalid, bus.err, bus.dout, e_rv, e_err, e_dout);
            end
            ref_dout = e_dout;
            if (bus.req && bus.we) model_write(bus.addr, bus.din, bus.wstrb);
        end
        idle_bus();
    endtask

    task automatic test_clear();
        int n;
        int bad;
        wr(7, 32'hA5A50001, 4'hF);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 7;
        tick();
        ref_dout = ref_mem[7];
        bus.clr = 1'b1; bus.req = 1'b1; bus.we = 1'b1; bus.addr = 3;
        bus.din = 32'hFFFFFFFF; bus.wstrb = 4'hF;
        tick();
        bus.clr = 1'b0; bus.we = 1'b0;
        checks++;
        if ({bus.busy, bus.ready, bus.rvalid} !== 3'b100) begin
            errors++;
            $display("FAIL clear_enter: got busy/ready/rvalid %b%b%b exp 100", bus.busy, bus.ready, bus.rvalid);
        end
        n = 0; bad = 0;
        while (bus.busy && n < 600) begin
            bus.addr = $urandom_range(0, 255);
            n++;
            tick();
            if (bus.rvalid || bus.err || bus.dout !== ref_dout) bad++;
        end
        bus.req = 1'b0;
        checks++;
        if (n !== 256) begin errors++; $display("FAIL clear_sweep_len: got %0d exp 256", n); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL clear_dropped_req: got %0d bad cycles exp 0", bad); end
        model_zero();
        for (int a = 0; a < 256; a++) begin
            bus.req = 1'b1; bus.we = 1'b0; bus.addr = a;
            tick();
            checks++;
            if ({bus.rvalid, bus.dout} !== {1'b1, ref_mem[a]}) begin
                errors++;
                $display("FAIL clear_zero[%0d]: got %b %h exp 1 %h", a, bus.rvalid, bus.dout, ref_mem[a]);
            end
        end
        bus.req = 1'b0;
        ref_dout = '0;
    endtask

    task automatic test_rst_mid_sweep();
        int n;
        wr(200, 32'h0BADF00D, 4'hF);
        wr(10, 32'h1234ABCD, 4'hF);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        for (int k = 0; k < 100; k++) tick();
        rst = 1'b1; bus.clr = 1'b1; bus.req = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if ({bus.busy, bus.ready, bus.dout} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL rst_held: got busy/ready %b%b dout %h exp 10 00000000", bus.busy, bus.ready, bus.dout);
        end
        rst = 1'b0; idle_bus();
        wait_sweep(n);
        checks++;
        if (n !== 256) begin errors++; $display("FAIL rst_restart_len: got %0d exp 256", n); end
        model_zero();
        ref_dout = '0;
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 200;
        tick();
        checks++;
        if ({bus.rvalid, bus.dout} !== {1'b1, ref_mem[200]}) begin
            errors++;
            $display("FAIL rst_restart_zero200: got %b %h exp 1 %h", bus.rvalid, bus.dout, ref_mem[200]);
        end
        bus.addr = 10;
        tick();
        checks++;
        if ({bus.rvalid, bus.dout} !== {1'b1, ref_mem[10]}) begin
            errors++;
            $display("FAIL rst_restart_zero10: got %b %h exp 1 %h", bus.rvalid, bus.dout, ref_mem[10]);
        end
        bus.req = 1'b0;
    endtask

    task automatic test_range();
        logic        e_rv, e_err;
        logic [31:0] e_dout;
        wr(44, 32'hCAFE0044, 4'hF);
        wr(300, 32'h00000BAD, 4'h3);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 300;
`ifdef DATA_MEMORY_RANGE_CHECK_EN
        e_rv = 1'b0; e_err = 1'b1; e_dout = ref_dout;
`else
        e_rv = 1'b1; e_err = 1'b0; e_dout = ref_mem[44];
`endif
        tick();
        bus.req = 1'b0;
        checks++;
        if ({bus.rvalid, bus.err, bus.dout} !== {e_rv, e_err, e_dout}) begin
            errors++;
            $display("FAIL range_read300: got %b %b %h exp %b %b %h", bus.rvalid, bus.err, bus.dout, e_rv, e_err, e_dout);
        end
        ref_dout = e_dout;
        tick();
        checks++;
        if ({bus.rvalid, bus.err} !== 2'b00) begin
            errors++;
            $display("FAIL range_pulse_end: got rvalid/err %b%b exp 00", bus.rvalid, bus.err);
        end
        bus.req = 1'b1; bus.addr = 44;
        tick();
        bus.req = 1'b0;
        checks++;
        if ({bus.rvalid, bus.dout} !== {1'b1, ref_mem[44]}) begin
            errors++;
            $display("FAIL range_mem44: got %b %h exp 1 %h", bus.rvalid, bus.dout, ref_mem[44]);
        end
    endtask

    initial begin
        idle_bus();
        test_reset();
        test_strobe();
        test_back_to_back();
        test_random_traffic();
        test_clear();
        test_rst_mid_sweep();
        test_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width in bits, a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 256: number of words.
REQ-003 SHALL have parameter ADDR_W, default 32: address port width in bits; addresses are word indices.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req  input  1  access request, qualified by ready.
REQ-007 SHALL have port we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 SHALL have port wstrb  input  WIDTH/8  byte-lane write enables; bit i covers din[8i+7:8i].
REQ-009 SHALL have port addr  input  ADDR_W  word address.
REQ-010 SHALL have port din  input  WIDTH  write data.
REQ-011 SHALL have port clr  input  1  request a full-array zero sweep.
REQ-012 SHALL have port ready  output  1  block accepts req this cycle.
REQ-013 SHALL have port rvalid  output  1  one-cycle pulse: dout carries read data.
REQ-014 SHALL have port dout  output  WIDTH  read data, registered, held between reads.
REQ-015 SHALL have port busy  output  1  clear sweep in progress.
REQ-016 SHALL have port err  output  1  one-cycle pulse: rejected out-of-range access (see REQ-033).

Function
REQ-017 SHALL implement FSM states CLEAR and IDLE only.
REQ-018 CLEAR: write all-zero to word clr_idx each cycle; clr_idx increments 0..DEPTH-1; busy=1, ready=0.
REQ-019 CLEAR -> IDLE in the cycle after clr_idx = DEPTH-1 is written; clr_idx returns to 0.
REQ-020 IDLE: ready=1, busy=0; clr=1 -> CLEAR next cycle, and any req in that cycle SHALL be ignored.
REQ-021 Accepted access = req & ready in a cycle.
REQ-022 Accepted write: per lane i with wstrb[i]=1, memory[addr] lane i <= din lane i; other lanes unchanged; no rvalid.
REQ-023 Accepted write with wstrb all zero SHALL leave memory unchanged and SHALL be otherwise a legal no-op.
REQ-024 Accepted read: next cycle rvalid=1 and dout=memory[addr] as of the acceptance edge; latency exactly 1 cycle.
REQ-025 Back-to-back reads SHALL be accepted every cycle, giving rvalid high on consecutive cycles.
REQ-026 Read of an address written in the immediately preceding cycle SHALL return the new data.
REQ-027 dout SHALL hold its last value when rvalid=0, including through CLEAR.
REQ-028 req while ready=0 SHALL be dropped, with no state change and no err; the requester retries.
REQ-029 Without REQ-033 logic, addr SHALL index memory modulo DEPTH (low bits only).

Reset
REQ-030 rst=1 at a clock edge SHALL force CLEAR with clr_idx=0, rvalid=0, err=0, dout=0; memory is then zeroed by the sweep.
REQ-031 rst asserted mid-sweep SHALL restart the sweep from index 0; rst held high keeps clr_idx at 0 and busy=1.
REQ-032 rst SHALL take priority over clr, req and sweep progress in the same cycle.

Configuration
REQ-033 With macro DATA_MEMORY_RANGE_CHECK_EN defined: an accepted access with addr >= DEPTH SHALL not modify memory, SHALL not raise rvalid, SHALL keep dout unchanged, and SHALL pulse err for one cycle on the next cycle.
REQ-034 Without DATA_MEMORY_RANGE_CHECK_EN: err SHALL be tied to 0 and REQ-029 wrap-around applies.

Verification
REQ-035 Reset then idle: rst 1 cycle -> busy=1 for exactly 256 cycles, then ready=1; read addr 0..255 all return 0.
REQ-036 Write addr 5, din 0xDEADBEEF, wstrb 0xF; then write addr 5, din 0x00000011, wstrb 0x1; read 5 -> rvalid next cycle, dout 0xDEADBE11.
REQ-037 Write addr 9 = 0x12345678, then a read of 9 in the very next cycle -> dout 0x12345678; four back-to-back reads -> four consecutive rvalid pulses.
REQ-038 clr pulsed in IDLE with req in the same cycle -> req ignored, busy for 256 cycles, all words 0; dout keeps its prior value.
REQ-039 rst at sweep cycle 100 -> sweep restarts, ready rises 256 cycles after rst deasserts.
REQ-040 Read addr 300: with DATA_MEMORY_RANGE_CHECK_EN -> err pulse, no rvalid, memory intact; without -> rvalid, dout = memory[44].
